// File: rtl/hdb3_decode_r_pkg.sv
// Shared HDB3 line-code constants for the encoder/decoder pair.
// Symbol encodings and the fixed decode latency live here so both ends agree.
package hdb3_decode_r_pkg;

    typedef logic [1:0] hdb3_sym_t;

    localparam hdb3_sym_t CODE_ZERO = 2'b00;
    localparam hdb3_sym_t CODE_POS  = 2'b01;
    localparam hdb3_sym_t CODE_NEG  = 2'b10;

    localparam int LATENCY = 4;

    // Valid-counter terminal value: o_valid is set on the LATENCY-th edge after reset.
    localparam logic [1:0] VALID_AT = 2'(LATENCY - 1);

endpackage

// File: rtl/hdb3_decode_r_viol_det.sv
// HDB3 polarity tracker: flags marks, bipolar violations and line-code errors.
// Holds the last mark polarity, the first-mark flag and a saturating zero-run count.
module hdb3_viol_det
    import hdb3_decode_r_pkg::*;
#(
    parameter hdb3_sym_t P_CODE_ZERO = CODE_ZERO,
    parameter hdb3_sym_t P_CODE_POS  = CODE_POS,
    parameter hdb3_sym_t P_CODE_NEG  = CODE_NEG
)(
    input  logic       clk,
    input  logic       rst_n,
    input  hdb3_sym_t  code,
    input  logic       win_busy,
    output logic       mark,
    output logic       viol,
    output logic       code_err
);

    logic       is_pos;
    logic       is_neg;
    logic       illegal;
    logic       last_pos_reg;
    logic       seen_reg;
    logic [1:0] zrun_reg;

    always_comb begin
        is_pos   = (code == P_CODE_POS);
        is_neg   = (code == P_CODE_NEG);
        mark     = is_pos | is_neg;
        illegal  = !mark && (code != P_CODE_ZERO);
        viol     = mark & seen_reg & (is_pos == last_pos_reg);
        // Illegal symbols count as zeros for the run-length rule.
        code_err = illegal
                 | (viol & win_busy)
                 | (!mark & seen_reg & (zrun_reg == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pos_reg <= 1'b0;
            seen_reg     <= 1'b0;
            zrun_reg     <= 2'd0;
        end else if (mark) begin
            last_pos_reg <= is_pos;
            seen_reg     <= 1'b1;
            zrun_reg     <= 2'd0;
        end else if (zrun_reg != 2'd3) begin
            zrun_reg     <= zrun_reg + 2'd1;
        end
    end

endmodule

// File: rtl/hdb3_decode_r.sv
// Registered HDB3 decoder: strips 000V/B00V windows and recovers NRZ data
// at a fixed latency of four cycles, with a one-cycle code-error pulse.
module hdb3_decode_r
    import hdb3_decode_r_pkg::*;
#(
    parameter hdb3_sym_t P_CODE_ZERO = CODE_ZERO,
    parameter hdb3_sym_t P_CODE_POS  = CODE_POS,
    parameter hdb3_sym_t P_CODE_NEG  = CODE_NEG
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  hdb3_sym_t  i_hdb3_code,
    output logic       o_data,
    output logic       o_valid,
    output logic       o_err
);

    logic               mark;
    logic               viol;
    logic               code_err;
    logic [LATENCY-1:0] d_reg;
    logic [LATENCY-1:0] d_next;
    logic [1:0]         vcnt_reg;
    logic               data_reg;
    logic               valid_reg;
    logic               err_pend_reg;
    logic               err_reg;

    hdb3_viol_det #(
        .P_CODE_ZERO (P_CODE_ZERO),
        .P_CODE_POS  (P_CODE_POS),
        .P_CODE_NEG  (P_CODE_NEG)
    ) u_viol_det (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .code     (i_hdb3_code),
        .win_busy (d_reg[0] | d_reg[1]),
        .mark     (mark),
        .viol     (viol),
        .code_err (code_err)
    );

    // A V zeroes itself and the three symbols before it, covering both 000V and B00V.
    assign d_next[0] = viol ? 1'b0 : mark;

    genvar gi;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_dly
            assign d_next[gi] = viol ? 1'b0 : d_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            d_reg        <= '0;
            vcnt_reg     <= 2'd0;
            data_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            err_pend_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            d_reg        <= d_next;
            data_reg     <= d_reg[LATENCY-1];
            // Two-stage error path so o_err leads the affected o_data by three cycles.
            err_pend_reg <= code_err;
            err_reg      <= err_pend_reg;
            if (vcnt_reg != VALID_AT) begin
                vcnt_reg <= vcnt_reg + 2'd1;
            end else begin
                valid_reg <= 1'b1;
            end
        end
    end

    assign o_data  = data_reg;
    assign o_valid = valid_reg;
    assign o_err   = err_reg;

endmodule

// File: tb/tb_hdb3_decode_r.sv
// Scoreboard bench for hdb3_decode_r: directed symbol vectors with hand-computed
// expected data and error streams, checked by a free-running negedge monitor.
module tb_hdb3_decode_r;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] code;
    logic       data;
    logic       valid;
    logic       err;

    int         checks   = 0;
    int         failures = 0;
    int         n_edges  = 0;
    string      tag      = "init";
    logic       exp_d_q[$];
    logic       exp_e_q[$];

    always #5 clk = ~clk;

    hdb3_decode_r dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hdb3_code (code),
        .o_data      (data),
        .o_valid     (valid),
        .o_err       (err)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %b required %b", tag, nm, act, exp);
        end
    endtask

    // Post-reset sampling edges seen by the DUT, saturating.
    always @(posedge clk) begin
        if (!rst_n)           n_edges <= 0;
        else if (n_edges < 8) n_edges <= n_edges + 1;
    end

    // Monitor: err is due one edge after the symbol's sampling edge, data four.
    always @(negedge clk) begin
        logic e;
        logic d;
        if (n_edges >= 1) chk("valid", valid, n_edges >= 4);
        if (n_edges >= 2) begin
            if (exp_e_q.size() == 0) begin
                chk("err_underflow", 1'b1, 1'b0);
            end else begin
                e = exp_e_q.pop_front();
                chk("err", err, e);
            end
        end
        if (n_edges >= 5) begin
            if (exp_d_q.size() == 0) begin
                chk("data_underflow", 1'b1, 1'b0);
            end else begin
                d = exp_d_q.pop_front();
                chk("data", data, d);
                $display("[%s] data=%b exp=%b err=%b valid=%b", tag, data, d, err, valid);
            end
        end
    end

    task automatic send(input byte s, input logic d, input logic e);
        case (s)
            "P":     code = 2'b01;
            "N":     code = 2'b10;
            "X":     code = 2'b11;
            default: code = 2'b00;
        endcase
        rst_n = 1'b1;
        exp_d_q.push_back(d);
        exp_e_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input string cs, input string ds, input string es);
        tag = name;
        for (int i = 0; i < cs.len(); i++) begin
            send(cs[i], ds[i] == "1", es[i] == "1");
        end
    endtask

    // Reset discards everything in flight, so pending expectations are dropped too.
    task automatic do_reset();
        rst_n = 1'b0;
        code  = 2'b00;
        @(posedge clk);
        #1;
        exp_d_q.delete();
        exp_e_q.delete();
        tag = "reset";
        chk("rst_data", data, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_err", err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        code  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // P=01, N=10, X=11, 0=00; each vector ends with five zero pads.
        run_vec("alt_marks", "PNPN00000",      "111100000",      "000000011");
        do_reset();
        run_vec("000V",      "P000P00000",     "1000000000",     "0000000011");
        do_reset();
        run_vec("B00V",      "PNP00P00000",    "11000000000",    "00000000011");
        do_reset();
        run_vec("illegal",   "PNXP00000",      "110100000",      "001000011");
        do_reset();
        run_vec("V_no_gap",  "PP00000",        "0000000",        "0100011");
        do_reset();
        run_vec("zero_run",  "P000000000",     "1000000000",     "0000111111");
        do_reset();
        run_vec("b2b_win",   "P000PN00N00000", "10000000000000", "00000000000011");
        do_reset();
        run_vec("rst_pre",   "P00",            "100",            "000");
        do_reset();
        run_vec("rst_post",  "P00000",         "100000",         "000011");
        do_reset();

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
